iwdg_cfg_seq: RTL and testbench

Wishbone master that configures, starts and periodically refreshes the IWDG slave over the same register bus. On a start pulse it runs the key-register unlock, writes prescaler and reload, polls the status register until update-idle, then writes the start key. After that it issues refresh writes (0xAAAA) on a programmable cycle interval or on demand, and reports bus faults.

---
 rtl/iwdg_cfg_seq.sv | 219 +++++++++++++++++++++
 tb/tb_iwdg_cfg_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/iwdg_cfg_seq.sv
// rtl/iwdg_cfg_seq.sv - Bus master that unlocks, configures, starts and refreshes an IWDG slave.
// Registered bus outputs; one idle cycle between transactions; faults are sticky until reset.
module iwdg_cfg_seq #(
    parameter int          GRL           = 1,
    parameter int          IWDG_PR_SIZE  = 3,
    parameter int          IWDG_RLR_SIZE = 12,
    parameter int          IWDG_ST_SIZE  = 2,
    parameter logic [31:0] IWDG_KR_ADR   = 32'h0100_0000,
    parameter logic [31:0] IWDG_PR_ADR   = 32'h0100_0004,
    parameter logic [31:0] IWDG_RLR_ADR  = 32'h0100_0008,
    parameter logic [31:0] IWDG_ST_ADR   = 32'h0100_000C,
    parameter int          KICK_W        = 16,
    parameter int          MAX_RETRY     = 4,
    parameter int          POLL_LIMIT    = 64
) (
    input  logic                     clk_m2s,
    input  logic                     rst_m2s,
    input  logic                     start,
    input  logic [IWDG_PR_SIZE-1:0]  cfg_pr,
    input  logic [IWDG_RLR_SIZE-1:0] cfg_rlr,
    input  logic [KICK_W-1:0]        kick_period,
    input  logic                     kick_req,
    output logic [31:0]              adr_m2s,
    output logic [31:0]              dat_m2s,
    output logic [GRL:0]             sel_m2s,
    output logic                     cyc_m2s,
    output logic                     stb_m2s,
    output logic                     we_m2s,
    output logic                     lok_m2s,
    input  logic [31:0]              dat_s2m,
    input  logic                     ack_s2m,
    input  logic                     err_s2m,
    input  logic                     rty_s2m,
    output logic                     busy,
    output logic                     running,
    output logic                     kick_done,
    output logic                     fault,
    output logic [1:0]               fault_code
);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam int PW = $clog2(POLL_LIMIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_UNLOCK, S_WR_PR, S_WR_RLR, S_POLL_ST, S_START, S_RUN, S_KICK, S_FAULT
    } state_t;

    state_t                   r_state, w_state_nx;
    logic [31:0]              r_adr, r_dat;
    logic [GRL:0]             r_sel;
    logic                     r_cyc, r_stb, r_we, r_lok, r_kick_done, r_fault, r_pend;
    logic [1:0]               r_fault_code;
    logic [IWDG_PR_SIZE-1:0]  r_pr;
    logic [IWDG_RLR_SIZE-1:0] r_rlr;
    logic [RW-1:0]            r_retry;
    logic [PW-1:0]            r_poll;
    logic [KICK_W-1:0]        r_kcnt;

    logic        w_bus_st, w_issue, w_err, w_rty, w_ack, w_st_zero;
    logic        w_tx_we, w_fault_set, w_retry_inc, w_poll_inc, w_unused;
    logic [1:0]  w_fault_code_nx;
    logic [31:0] w_tx_adr, w_tx_dat;

    // Responses only count while a cycle is outstanding; err outranks rty, rty outranks ack.
    assign w_err     = r_cyc & err_s2m;
    assign w_rty     = r_cyc & ~err_s2m & rty_s2m;
    assign w_ack     = r_cyc & ~err_s2m & ~rty_s2m & ack_s2m;
    assign w_st_zero = (dat_s2m[IWDG_ST_SIZE-1:0] == '0);
    assign w_unused  = ^dat_s2m[31:IWDG_ST_SIZE];

    assign w_bus_st = (r_state == S_UNLOCK) || (r_state == S_WR_PR) || (r_state == S_WR_RLR) ||
                      (r_state == S_POLL_ST) || (r_state == S_START) || (r_state == S_KICK);
    assign w_issue  = w_bus_st & ~r_cyc;

    always_comb begin
        w_tx_adr = IWDG_KR_ADR;
        w_tx_dat = 32'h0;
        w_tx_we  = 1'b1;
        case (r_state)
            S_UNLOCK:  w_tx_dat = 32'h0000_5555;
            S_WR_PR:   begin w_tx_adr = IWDG_PR_ADR;  w_tx_dat = 32'(r_pr);  end
            S_WR_RLR:  begin w_tx_adr = IWDG_RLR_ADR; w_tx_dat = 32'(r_rlr); end
            S_POLL_ST: begin w_tx_adr = IWDG_ST_ADR;  w_tx_we  = 1'b0;       end
            S_START:   w_tx_dat = 32'h0000_CCCC;
            S_KICK:    w_tx_dat = 32'h0000_AAAA;
            default:   w_tx_dat = 32'h0;
        endcase
    end

    always_ff @(posedge clk_m2s or posedge rst_m2s) begin
        if (rst_m2s) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx      = r_state;
        w_fault_set     = 1'b0;
        w_fault_code_nx = 2'd0;
        w_retry_inc     = 1'b0;
        w_poll_inc      = 1'b0;
        if (w_err) begin
            w_state_nx      = S_FAULT;
            w_fault_set     = 1'b1;
            w_fault_code_nx = 2'd1;
        end else if (w_rty) begin
            if (r_retry == RW'(MAX_RETRY)) begin
                w_state_nx      = S_FAULT;
                w_fault_set     = 1'b1;
                w_fault_code_nx = 2'd2;
            end else begin
                w_retry_inc = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE:   if (start) w_state_nx = S_UNLOCK;
                S_UNLOCK: if (w_ack) w_state_nx = S_WR_PR;
                S_WR_PR:  if (w_ack) w_state_nx = S_WR_RLR;
                S_WR_RLR: if (w_ack) w_state_nx = S_POLL_ST;
                S_POLL_ST: begin
                    if (w_ack) begin
                        if (w_st_zero) begin
                            w_state_nx = S_START;
                        end else if (r_poll == PW'(POLL_LIMIT - 1)) begin
                            w_state_nx      = S_FAULT;
                            w_fault_set     = 1'b1;
                            w_fault_code_nx = 2'd3;
                        end else begin
                            w_poll_inc = 1'b1;
                        end
                    end
                end
                S_START:  if (w_ack) w_state_nx = S_RUN;
                S_RUN: begin
                    if (kick_req || r_pend || (r_kcnt == KICK_W'(1) && kick_period != '0))
                        w_state_nx = S_KICK;
                end
                S_KICK:   if (w_ack) w_state_nx = S_RUN;
                default:  w_state_nx = r_state;
            endcase
        end
    end

    always_ff @(posedge clk_m2s or posedge rst_m2s) begin
        if (rst_m2s) begin
            r_adr        <= '0;
            r_dat        <= '0;
            r_sel        <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_lok        <= 1'b0;
            r_kick_done  <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'd0;
            r_pend       <= 1'b0;
            r_pr         <= '0;
            r_rlr        <= '0;
            r_retry      <= '0;
            r_poll       <= '0;
            r_kcnt       <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_pr  <= cfg_pr;
                r_rlr <= cfg_rlr;
            end

            if ((r_state == S_IDLE && start) || w_ack) r_retry <= '0;
            else if (w_retry_inc)                    r_retry <= r_retry + RW'(1);

            if (r_state == S_IDLE && start) r_poll <= '0;
            else if (w_poll_inc)            r_poll <= r_poll + PW'(1);

            if (w_fault_set) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_fault_code_nx;
            end

            if (w_issue) begin
                r_adr <= w_tx_adr;
                r_dat <= w_tx_dat;
                r_we  <= w_tx_we;
                r_sel <= '1;
                r_cyc <= 1'b1;
                r_stb <= 1'b1;
            end else if (w_err || w_rty || w_ack) begin
                r_adr <= '0;
                r_dat <= '0;
                r_we  <= 1'b0;
                r_sel <= '0;
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
            end

            // The lock spans the whole configuration, gaps included, and ends on START ack or fault.
            if (w_issue && r_state == S_UNLOCK)                 r_lok <= 1'b1;
            else if (w_state_nx == S_RUN || w_state_nx == S_FAULT) r_lok <= 1'b0;

            r_kick_done <= w_ack && (r_state == S_KICK);

            if (w_state_nx == S_RUN && r_state != S_RUN)   r_kcnt <= kick_period;
            else if (r_state == S_RUN && r_kcnt != '0)     r_kcnt <= r_kcnt - KICK_W'(1);

            if (r_state == S_KICK && kick_req)                    r_pend <= 1'b1;
            else if (r_state == S_RUN && w_state_nx == S_KICK)    r_pend <= 1'b0;
        end
    end

    assign adr_m2s    = r_adr;
    assign dat_m2s    = r_dat;
    assign sel_m2s    = r_sel;
    assign cyc_m2s    = r_cyc;
    assign stb_m2s    = r_stb;
    assign we_m2s     = r_we;
    assign lok_m2s    = r_lok;
    assign kick_done  = r_kick_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign running    = (r_state == S_RUN) || (r_state == S_KICK);
    assign busy       = (r_state != S_IDLE) && (r_state != S_RUN) && (r_state != S_FAULT);
endmodule

// File: tb/tb_iwdg_cfg_seq.sv
// tb/tb_iwdg_cfg_seq.sv - Directed self-checking bench for iwdg_cfg_seq.
// A task-based slave answers each transaction with ack, rty, err or err+ack.
module tb_iwdg_cfg_seq;
    localparam logic [31:0] KR  = 32'h0100_0000;
    localparam logic [31:0] PR  = 32'h0100_0004;
    localparam logic [31:0] RLR = 32'h0100_0008;
    localparam logic [31:0] ST  = 32'h0100_000C;
    localparam int R_ACK = 0, R_RTY = 1, R_ERR = 2, R_ERRACK = 3;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, kick_req = 1'b0;
    logic [2:0]  cfg_pr = '0;
    logic [11:0] cfg_rlr = '0;
    logic [15:0] kick_period = '0;
    logic [31:0] adr, dat_m2s, dat_s2m = '0;
    logic [1:0]  sel;
    logic        cyc, stb, we, lok, ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic        busy, running, kick_done, fault;
    logic [1:0]  fault_code;

    int n_assert = 0, n_fail = 0;
    int          g_wait, cnt;
    logic [31:0] g_adr, g_dat, s_adr, s_dat;
    logic        g_we, g_lok;
    logic [1:0]  g_sel;

    iwdg_cfg_seq dut (
        .clk_m2s(clk), .rst_m2s(rst), .start(start), .cfg_pr(cfg_pr), .cfg_rlr(cfg_rlr),
        .kick_period(kick_period), .kick_req(kick_req),
        .adr_m2s(adr), .dat_m2s(dat_m2s), .sel_m2s(sel), .cyc_m2s(cyc), .stb_m2s(stb),
        .we_m2s(we), .lok_m2s(lok), .dat_s2m(dat_s2m), .ack_s2m(ack), .err_s2m(err),
        .rty_s2m(rty), .busy(busy), .running(running), .kick_done(kick_done),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic txn(input int resp, input logic [31:0] rdata);
        g_wait = 0;
        do begin
            @(negedge clk);
            g_wait++;
        end while (!(cyc && stb) && g_wait < 300);
        chk("txn_seen", {31'b0, cyc && stb}, 32'h1);
        g_adr = adr; g_dat = dat_m2s; g_we = we; g_lok = lok; g_sel = sel;
        dat_s2m = rdata;
        ack = (resp == R_ACK) || (resp == R_ERRACK);
        rty = (resp == R_RTY);
        err = (resp == R_ERR) || (resp == R_ERRACK);
        @(negedge clk);
        ack = 1'b0; rty = 1'b0; err = 1'b0; dat_s2m = '0;
    endtask

    task automatic do_start(input logic [2:0] pr, input logic [11:0] rl);
        @(negedge clk);
        start = 1'b1; cfg_pr = pr; cfg_rlr = rl;
        @(negedge clk);
        start = 1'b0; cfg_pr = '0; cfg_rlr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic quiet(input int cycles, input string tag);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (cyc) cnt++;
        end
        chk(tag, cnt, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cyc", cyc, 0);        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);          chk("rst_lok", lok, 0);
        chk("rst_sel", sel, 0);        chk("rst_adr", adr, 0);
        chk("rst_dat", dat_m2s, 0);    chk("rst_busy", busy, 0);
        chk("rst_running", running, 0); chk("rst_kick_done", kick_done, 0);
        chk("rst_fault", fault, 0);    chk("rst_fault_code", fault_code, 0);
        rst = 1'b0;
        kick_period = 16'd10;

        // Full configuration with 1-cycle acks
        do_start(3'd3, 12'hFFF);
        chk("t1_busy", busy, 1);
        chk("t1_no_cyc_yet", cyc, 0);
        txn(R_ACK, 0);
        chk("t1_kr_adr", g_adr, KR);   chk("t1_kr_dat", g_dat, 32'h5555);
        chk("t1_kr_we", g_we, 1);      chk("t1_kr_lok", g_lok, 1);
        chk("t1_kr_sel", g_sel, 2'b11); chk("t1_kr_wait", g_wait, 1);
        chk("t1_gap_cyc", cyc, 0);     chk("t1_gap_lok", lok, 1);
        txn(R_ACK, 0);
        chk("t1_pr_adr", g_adr, PR);   chk("t1_pr_dat", g_dat, 32'h3);
        chk("t1_pr_wait", g_wait, 1);  chk("t1_pr_lok", g_lok, 1);
        txn(R_ACK, 0);
        chk("t1_rlr_adr", g_adr, RLR); chk("t1_rlr_dat", g_dat, 32'hFFF);
        txn(R_ACK, 0);
        chk("t1_st_adr", g_adr, ST);   chk("t1_st_we", g_we, 0);
        txn(R_ACK, 0);
        chk("t1_start_adr", g_adr, KR); chk("t1_start_dat", g_dat, 32'hCCCC);
        chk("t1_start_lok", g_lok, 1);
        chk("t1_running", running, 1); chk("t1_busy_run", busy, 0);
        chk("t1_lok_run", lok, 0);

        // Periodic refresh: 10 RUN cycles, then one issue cycle
        txn(R_ACK, 0);
        chk("t2_kick1_wait", g_wait, 11); chk("t2_kick1_adr", g_adr, KR);
        chk("t2_kick1_dat", g_dat, 32'hAAAA); chk("t2_kick1_lok", g_lok, 0);
        chk("t2_kick_done_hi", kick_done, 1);
        @(negedge clk);
        chk("t2_kick_done_lo", kick_done, 0);
        txn(R_ACK, 0);
        chk("t2_kick2_wait", g_wait, 10); chk("t2_kick2_dat", g_dat, 32'hAAAA);

        // Automatic refresh off; two requests during one KICK merge into one extra refresh
        kick_period = 16'd0;
        quiet(25, "t6_no_auto_kick");
        @(negedge clk); kick_req = 1'b1;
        @(negedge clk); kick_req = 1'b1;
        @(negedge clk); kick_req = 1'b0;
        @(negedge clk); kick_req = 1'b1;
        @(negedge clk); kick_req = 1'b0;
        txn(R_ACK, 0);
        chk("t6_req_kick_dat", g_dat, 32'hAAAA); chk("t6_req_kick_wait", g_wait, 1);
        txn(R_ACK, 0);
        chk("t6_pend_kick_dat", g_dat, 32'hAAAA); chk("t6_pend_kick_wait", g_wait, 2);
        quiet(30, "t6_single_extra");

        // Asynchronous reset in the middle of a refresh write
        @(negedge clk); kick_req = 1'b1;
        @(negedge clk); kick_req = 1'b0;
        @(negedge clk);
        chk("t6_cyc_before_rst", cyc, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_cyc", cyc, 0);   chk("t6_async_stb", stb, 0);
        chk("t6_async_adr", adr, 0);   chk("t6_async_dat", dat_m2s, 0);
        chk("t6_async_sel", sel, 0);   chk("t6_async_running", running, 0);
        @(negedge clk);
        rst = 1'b0;
        quiet(10, "t6_no_restart");

        // Status polling: three busy reads, then idle
        do_start(3'd1, 12'h123);
        txn(R_ACK, 0);
        txn(R_ACK, 0); chk("t3_pr_dat", g_dat, 32'h1);
        txn(R_ACK, 0); chk("t3_rlr_dat", g_dat, 32'h123);
        for (int i = 0; i < 3; i++) begin
            txn(R_ACK, 32'h1);
            chk("t3_poll_adr", g_adr, ST); chk("t3_poll_wait", g_wait, 1);
        end
        txn(R_ACK, 32'h0);
        chk("t3_poll_last_adr", g_adr, ST);
        txn(R_ACK, 0);
        chk("t3_start_dat", g_dat, 32'hCCCC); chk("t3_running", running, 1);

        // Status stuck nonzero: poll limit fault
        do_reset();
        do_start(3'd0, 12'h0);
        repeat (3) txn(R_ACK, 0);
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            txn(R_ACK, 32'h3);
            if (g_adr == ST) cnt++;
            if (i == 62) chk("t3_no_fault_63", fault, 0);
        end
        chk("t3_st_reads", cnt, 64);
        chk("t3_fault", fault, 1);     chk("t3_fault_code", fault_code, 3);
        chk("t3_fault_cyc", cyc, 0);   chk("t3_fault_lok", lok, 0);
        chk("t3_fault_busy", busy, 0);
        quiet(5, "t3_fault_quiet");

        // Retry on PR write twice, then ack
        do_reset();
        do_start(3'd5, 12'h0AB);
        txn(R_ACK, 0);
        txn(R_RTY, 0); s_adr = g_adr; s_dat = g_dat;
        chk("t4_pr_adr", s_adr, PR);   chk("t4_pr_dat", s_dat, 32'h5);
        txn(R_RTY, 0);
        chk("t4_retry1_adr", g_adr, PR); chk("t4_retry1_dat", g_dat, 32'h5);
        chk("t4_retry1_gap", g_wait, 1);
        txn(R_ACK, 0);
        chk("t4_retry2_adr", g_adr, PR); chk("t4_retry2_dat", g_dat, 32'h5);
        txn(R_ACK, 0); chk("t4_rlr_dat", g_dat, 32'hAB);
        txn(R_ACK, 0);
        txn(R_ACK, 0);
        chk("t4_running", running, 1); chk("t4_no_fault", fault, 0);

        // Retry limit
        do_reset();
        do_start(3'd5, 12'h0AB);
        txn(R_ACK, 0);
        repeat (4) txn(R_RTY, 0);
        chk("t4_fault_after_4", fault, 0);
        txn(R_RTY, 0);
        chk("t4_fault", fault, 1);     chk("t4_fault_code", fault_code, 2);
        chk("t4_fault_cyc", cyc, 0);

        // err together with ack on RLR
        do_reset();
        do_start(3'd2, 12'h456);
        txn(R_ACK, 0);
        txn(R_ACK, 0);
        txn(R_ERRACK, 0);
        chk("t5_rlr_adr", g_adr, RLR);
        chk("t5_fault", fault, 1);     chk("t5_fault_code", fault_code, 1);
        chk("t5_cyc", cyc, 0);         chk("t5_running", running, 0);
        chk("t5_busy", busy, 0);       chk("t5_lok", lok, 0);
        do_start(3'd1, 12'h1);
        @(negedge clk); kick_req = 1'b1;
        @(negedge clk); kick_req = 1'b0;
        quiet(10, "t5_ignored");
        chk("t5_code_sticky", fault_code, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
